// File: rtl/stopwatch_ctrl.sv
// Purpose: stopwatch mode/timing controller; conditions buttons/switches, runs RUN/PAUSED/ADJ FSM.
// Latency: stable raw button rise to registered effect (clr pulse, paused/state) = DB_CYCLES+3 edges.
// Backpressure: none; all enables are single-cycle fire-and-forget pulses to the digit counters.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_pause_btn, i_clr_btn       raw active-high buttons (asynchronous to i_clk)
//   i_adj_sw, i_sel_sw           raw switches: adjust mode, field select (0 min, 1 sec)
//   o_cnt_en, o_adj_en, o_clr    single-cycle pulses: count second, adjust field, clear digits
//   o_adj_sel                    debounced select switch
//   o_blink                      1 = selected field visible
//   o_state                      00 RUN, 01 PAUSED, 10 ADJ
// Build option: define STOPWATCH_CTRL_BLINK_EN to make o_blink toggle every BLINK_DIV cycles in ADJ;
// otherwise o_blink is held at 1 and the blink divider does not exist.
module stopwatch_ctrl #(
  parameter int ONE_HZ_DIV = 100_000_000,
  parameter int TWO_HZ_DIV = 50_000_000,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int DB_CYCLES  = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pause_btn,
  input  logic       i_clr_btn,
  input  logic       i_adj_sw,
  input  logic       i_sel_sw,
  output logic       o_cnt_en,
  output logic       o_adj_en,
  output logic       o_adj_sel,
  output logic       o_clr,
  output logic       o_blink,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PAUSED = 2'b01,
    ST_ADJ    = 2'b10
  } state_t;

  localparam int D1W = $clog2(ONE_HZ_DIV);
  localparam int D2W = $clog2(TWO_HZ_DIV);
  localparam int DBW = $clog2(DB_CYCLES);
  localparam logic [D1W-1:0] D1_LAST = D1W'(ONE_HZ_DIV - 1);
  localparam logic [D2W-1:0] D2_LAST = D2W'(TWO_HZ_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  // Widths above assume at least two cycles per period.
  if (ONE_HZ_DIV < 2 || TWO_HZ_DIV < 2 || BLINK_DIV < 2 || DB_CYCLES < 2) begin : g_param_check
    $error("stopwatch_ctrl: divider and debounce parameters must be >= 2");
  end

  // Bit order for the input path: 0 pause, 1 clear, 2 adjust, 3 select.
  logic [3:0]          w_raw;
  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  logic [3:0]          r_db_lvl;
  logic [3:0][DBW-1:0] r_db_cnt;
  logic [1:0]          r_btn_d;

  logic                w_pause_press;
  logic                w_clr_press;
  logic                w_adj_db;
  logic                w_tick1;
  logic                w_tick2;
  logic                w_paused_nxt;
  logic                w_is_run;
  logic                w_is_adj;
  state_t              w_state_nxt;

  state_t              r_state;
  logic                r_paused;
  logic [D1W-1:0]      r_div1;
  logic [D2W-1:0]      r_div2;
  logic                r_cnt_en;
  logic                r_adj_en;
  logic                r_clr;

  assign w_raw = {i_sel_sw, i_adj_sw, i_clr_btn, i_pause_btn};

  // Synchronizer plus debouncer. The counter tracks how long the synchronized sample has
  // disagreed with the accepted level; any agreement restarts it, so DB_CYCLES consecutive
  // disagreeing samples are needed before the new level is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_db_lvl <= '0;
      r_db_cnt <= '0;
      r_btn_d  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_btn_d <= r_db_lvl[1:0];
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_lvl[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign w_pause_press = r_db_lvl[0] & ~r_btn_d[0];
  assign w_clr_press   = r_db_lvl[1] & ~r_btn_d[1];
  assign w_adj_db      = r_db_lvl[2];
  assign w_tick1       = (r_div1 == D1_LAST);
  assign w_tick2       = (r_div2 == D2_LAST);
  // The FSM sees the post-toggle flag so a pause press and an ADJ exit on the same edge agree.
  assign w_paused_nxt  = r_paused ^ w_pause_press;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    w_is_run    = 1'b0;
    w_is_adj    = 1'b0;
    if (w_adj_db) begin
      w_state_nxt = ST_ADJ;
    end else if (w_paused_nxt) begin
      w_state_nxt = ST_PAUSED;
    end
    // The unused encoding 11 behaves as RUN.
    case (r_state)
      ST_PAUSED: w_is_run = 1'b0;
      ST_ADJ:    w_is_adj = 1'b1;
      default:   w_is_run = 1'b1;
    endcase
  end

  // Dividers free-run in every state; a clear press re-phases both so the next count
  // arrives a full period after the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_paused <= 1'b0;
      r_div1   <= '0;
      r_div2   <= '0;
      r_cnt_en <= 1'b0;
      r_adj_en <= 1'b0;
      r_clr    <= 1'b0;
    end else begin
      r_paused <= w_paused_nxt;
      r_div1   <= (w_clr_press || w_tick1) ? '0 : r_div1 + D1W'(1);
      r_div2   <= (w_clr_press || w_tick2) ? '0 : r_div2 + D2W'(1);
      r_cnt_en <= w_tick1 & w_is_run & ~w_clr_press;
      r_adj_en <= w_tick2 & w_is_adj & ~w_clr_press;
      r_clr    <= w_clr_press;
    end
  end

`ifdef STOPWATCH_CTRL_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] r_bdiv;
  logic          r_blink;

  // Held at visible/zero outside ADJ and on the entry edge, so every ADJ visit starts visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bdiv  <= '0;
      r_blink <= 1'b1;
    end else if (!w_is_adj || (w_state_nxt != ST_ADJ)) begin
      r_bdiv  <= '0;
      r_blink <= 1'b1;
    end else if (r_bdiv == B_LAST) begin
      r_bdiv  <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_bdiv  <= r_bdiv + BW'(1);
    end
  end

  assign o_blink = r_blink;
`else
  assign o_blink = 1'b1;
`endif

  assign o_cnt_en  = r_cnt_en;
  assign o_adj_en  = r_adj_en;
  assign o_clr     = r_clr;
  assign o_adj_sel = r_db_lvl[3];
  assign o_state   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with small divider/debounce values (10, 5, 3, 4).
// Timeline is tracked in edges since reset release (cyc); expectations are hand-computed.
module tb_stopwatch_ctrl;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       pause_btn = 1'b0;
  logic       clr_btn   = 1'b0;
  logic       adj_sw    = 1'b0;
  logic       sel_sw    = 1'b0;
  logic       cnt_en;
  logic       adj_en;
  logic       adj_sel;
  logic       clr;
  logic       blink;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_cnt = 0;
  int n_adj = 0;
  int n_clr = 0;

  typedef struct {
    logic       p;
    logic       c;
    logic       a;
    logic       s;
    int         n;
    logic [1:0] st;
    logic       sel;
    int         cnt;
    int         adj;
    int         clr;
  } vec_t;

  vec_t tbl[14];

  stopwatch_ctrl #(
    .ONE_HZ_DIV(10),
    .TWO_HZ_DIV(5),
    .BLINK_DIV (3),
    .DB_CYCLES (4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_pause_btn(pause_btn),
    .i_clr_btn  (clr_btn),
    .i_adj_sw   (adj_sw),
    .i_sel_sw   (sel_sw),
    .o_cnt_en   (cnt_en),
    .o_adj_en   (adj_en),
    .o_adj_sel  (adj_sel),
    .o_clr      (clr),
    .o_blink    (blink),
    .o_state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    n_cnt += int'(cnt_en);
    n_adj += int'(adj_en);
    n_clr += int'(clr);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},   int'(state),   0);
    check({tag, "_cnt_en"},  int'(cnt_en),  0);
    check({tag, "_adj_en"},  int'(adj_en),  0);
    check({tag, "_clr"},     int'(clr),     0);
    check({tag, "_adj_sel"}, int'(adj_sel), 0);
    check({tag, "_blink"},   int'(blink),   1);
  endtask

  initial begin
    int exp_blink;

    //          p     c     a     s     n   st     sel   cnt adj clr
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'b01, 1'b0, 0,  0,  0};  // pause release, stay paused
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 2'b00, 1'b0, 1,  0,  0};  // resume, tick at 80
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'b00, 1'b0, 1,  0,  0};  // tick at 90
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3,  2'b00, 1'b0, 0,  0,  0};  // 3-cycle glitch
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7,  2'b00, 1'b0, 1,  0,  0};  // glitch ignored, tick at 100
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10, 2'b10, 1'b1, 0,  1,  0};  // ADJ at 107, adj tick 110
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 20, 2'b10, 1'b1, 0,  4,  0};  // adj every 5, no counts
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 2'b10, 1'b0, 0,  2,  0};  // select minutes
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10, 2'b10, 1'b0, 0,  2,  0};  // pause in ADJ, stay ADJ
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'b01, 1'b0, 0,  1,  0};  // leave ADJ into PAUSED
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 2'b01, 1'b0, 0,  0,  1};  // clear while paused
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'b01, 1'b0, 0,  0,  0};  // clear held = one pulse
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 2'b00, 1'b0, 0,  0,  0};  // resume on tick edge 187
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'b00, 1'b0, 1,  0,  0};  // re-phased tick at 197

    // Reset values, then free-running count from release.
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      check("idle_cnt_en", int'(cnt_en), int'(cyc % 10 == 0));
    end
    check("idle_state", int'(state), 0);

    // Pause press latency: effect lands on the 7th edge after the raw rise.
    pause_btn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("press_lat_state", int'(state), 0);
    end
    step();
    check("press_lat_state", int'(state), 1);
    n_cnt = 0;
    repeat (13) step();
    check("paused_no_cnt", n_cnt, 0);
    pause_btn = 1'b0;

    for (int i = 0; i < 14; i++) begin
      pause_btn = tbl[i].p;
      clr_btn   = tbl[i].c;
      adj_sw    = tbl[i].a;
      sel_sw    = tbl[i].s;
      n_cnt = 0;
      n_adj = 0;
      n_clr = 0;
      repeat (tbl[i].n) step();
      check($sformatf("vec%0d_state", i),   int'(state),   int'(tbl[i].st));
      check($sformatf("vec%0d_adj_sel", i), int'(adj_sel), int'(tbl[i].sel));
      check($sformatf("vec%0d_cnt", i),     n_cnt,         tbl[i].cnt);
      check($sformatf("vec%0d_adj", i),     n_adj,         tbl[i].adj);
      check($sformatf("vec%0d_clr", i),     n_clr,         tbl[i].clr);
    end
    pause_btn = 1'b0;

    // Clear press landing on the 1 Hz tick edge (207).
    clr_btn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("clr_early", int'(clr), 0);
    end
    step();
    check("clr_on_tick_clr", int'(clr), 1);
    check("clr_on_tick_cnt_en", int'(cnt_en), 0);
    check("clr_on_tick_state", int'(state), 0);
    clr_btn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("clr_after_cnt_en", int'(cnt_en), int'(cyc == 217));
      check("clr_after_clr", int'(clr), 0);
    end

    // ADJ entry: exact adj_en cadence and blink phase.
    adj_sw = 1'b1;
    sel_sw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("adj_state", int'(state), (cyc >= 224) ? 2 : 0);
      check("adj_adj_sel", int'(adj_sel), int'(cyc >= 223));
      check("adj_adj_en", int'(adj_en), int'(cyc == 227 || cyc == 232 || cyc == 237));
      check("adj_cnt_en", int'(cnt_en), 0);
`ifdef STOPWATCH_CTRL_BLINK_EN
      exp_blink = (cyc < 224) ? 1 : int'((((cyc - 224) / 3) % 2) == 0);
`else
      exp_blink = 1;
`endif
      check("adj_blink", int'(blink), exp_blink);
    end

    // Asynchronous reset while in ADJ with a pause press mid-debounce.
    pause_btn = 1'b1;
    repeat (3) step();
    #2;
    rst_n  = 1'b0;
    adj_sw = 1'b0;
    sel_sw = 1'b0;
    #1;
    check_reset("reset_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    // Pause still held: it must debounce again from scratch.
    for (int k = 0; k < 6; k++) begin
      step();
      check("redebounce_state", int'(state), 0);
    end
    step();
    check("redebounce_state", int'(state), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
